// File: rtl/deflate_bit_packer_if.sv
// Chunk-in / packed-word-out bus for deflate_bit_packer.
// master drives chunks and flush; slave is the packer.
interface deflate_bit_packer_if #(
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned BITCNT_WIDTH = 32
);
  logic                    lz77_filt_valid;
  logic [5:0]              lz77_filt_size;
  logic [OUT_WIDTH-1:0]    lz77_filt_data;
  logic                    flush_in;
  logic                    pack_valid;
  logic [OUT_WIDTH-1:0]    pack_data;
  logic                    pack_last;
  logic [2:0]              pack_byte_cnt;
  logic [BITCNT_WIDTH-1:0] pack_bit_total;
  logic                    busy;
  logic                    protocol_err;

  modport master (
    output lz77_filt_valid, lz77_filt_size, lz77_filt_data, flush_in,
    input  pack_valid, pack_data, pack_last, pack_byte_cnt, pack_bit_total, busy, protocol_err
  );

  modport slave (
    input  lz77_filt_valid, lz77_filt_size, lz77_filt_data, flush_in,
    output pack_valid, pack_data, pack_last, pack_byte_cnt, pack_bit_total, busy, protocol_err
  );
endinterface

// File: rtl/deflate_bit_packer.sv
// Packs 0..32-bit code chunks MSB-first into 32-bit words; flush pads to a byte boundary.
// Optional DEFLATE_BIT_PACKER_HEADER_EN preloads the 3-bit block header 110 after reset/flush.
module deflate_bit_packer #(
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned BITCNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  deflate_bit_packer_if.slave  bus
);

`ifdef DEFLATE_BIT_PACKER_HEADER_EN
  localparam logic [63:0] AccInit  = {3'b110, 61'd0};
  localparam logic [6:0]  FillInit = 7'd3;
`else
  localparam logic [63:0] AccInit  = 64'd0;
  localparam logic [6:0]  FillInit = 7'd0;
`endif
  localparam logic [BITCNT_WIDTH-1:0] TotalInit = BITCNT_WIDTH'(FillInit);

  typedef enum logic {StRun, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             acc_q, acc_d;
  logic [6:0]              fill_q, fill_d;
  logic                    pack_valid_q, pack_valid_d;
  logic [OUT_WIDTH-1:0]    pack_data_q, pack_data_d;
  logic                    pack_last_q, pack_last_d;
  logic [2:0]              pack_byte_cnt_q, pack_byte_cnt_d;
  logic [BITCNT_WIDTH-1:0] bit_total_q, bit_total_d;
  logic                    err_q, err_d;

  logic                    size_ovf;
  logic [5:0]              size_eff;
  logic                    accept;
  logic [6:0]              add_size;
  logic [63:0]             chunk_mask, chunk_ext, chunk_shifted;
  logic [7:0]              shamt;
  logic [63:0]             acc_app;
  logic [6:0]              fill_app;
  logic [6:0]              fin_fill;
  logic [OUT_WIDTH-1:0]    fin_word;
  logic [2:0]              fin_bytes;
  logic [6:0]              fin_pad;

  // Append: new chunk lands directly below the bits already held.
  always_comb begin
    size_ovf      = bus.lz77_filt_size > 6'd32;
    size_eff      = size_ovf ? 6'd32 : bus.lz77_filt_size;
    accept        = bus.lz77_filt_valid && (state_q == StRun);
    add_size      = accept ? {1'b0, size_eff} : 7'd0;
    chunk_mask    = ~(64'hFFFF_FFFF_FFFF_FFFF << size_eff);
    chunk_ext     = {32'd0, bus.lz77_filt_data} & chunk_mask;
    shamt         = 8'd64 - {1'b0, fill_q} - {2'b00, size_eff};
    chunk_shifted = chunk_ext << shamt;
    acc_app       = accept ? (acc_q | chunk_shifted) : acc_q;
    fill_app      = fill_q + add_size;
    fin_fill      = (state_q == StFlush) ? fill_q : fill_app;
    fin_word      = (state_q == StFlush) ? acc_q[63:32] : acc_app[63:32];
    fin_bytes     = 3'((fin_fill + 7'd7) >> 3);
    fin_pad       = {1'b0, fin_bytes, 3'b000} - fin_fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.flush_in && (fill_app >= 7'd32)) state_d = StFlush;
      StFlush: state_d = StRun;
    endcase
  end

  always_comb begin
    acc_d           = acc_q;
    fill_d          = fill_q;
    pack_valid_d    = 1'b0;
    pack_data_d     = pack_data_q;
    pack_last_d     = 1'b0;
    pack_byte_cnt_d = pack_byte_cnt_q;
    bit_total_d     = bit_total_q;
    err_d           = err_q;
    unique case (state_q)
      StRun: begin
        bit_total_d = bit_total_q + BITCNT_WIDTH'(add_size);
        if (bus.lz77_filt_valid && size_ovf) err_d = 1'b1;
        if (fill_app >= 7'd32) begin
          pack_valid_d    = 1'b1;
          pack_data_d     = acc_app[63:32];
          pack_byte_cnt_d = 3'd4;
          acc_d           = acc_app << 32;
          fill_d          = fill_app - 7'd32;
        end else if (bus.flush_in) begin
          pack_valid_d    = 1'b1;
          pack_data_d     = fin_word;
          pack_last_d     = 1'b1;
          pack_byte_cnt_d = fin_bytes;
          bit_total_d     = bit_total_q + BITCNT_WIDTH'(add_size) + BITCNT_WIDTH'(fin_pad)
                            + TotalInit;
          acc_d           = AccInit;
          fill_d          = FillInit;
        end else begin
          acc_d  = acc_app;
          fill_d = fill_app;
        end
      end
      StFlush: begin
        // Chunks arriving while the remainder drains are lost.
        if (bus.lz77_filt_valid) err_d = 1'b1;
        pack_valid_d    = 1'b1;
        pack_data_d     = fin_word;
        pack_last_d     = 1'b1;
        pack_byte_cnt_d = fin_bytes;
        bit_total_d     = bit_total_q + BITCNT_WIDTH'(fin_pad) + TotalInit;
        acc_d           = AccInit;
        fill_d          = FillInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q           <= AccInit;
      fill_q          <= FillInit;
      pack_valid_q    <= 1'b0;
      pack_data_q     <= '0;
      pack_last_q     <= 1'b0;
      pack_byte_cnt_q <= 3'd0;
      bit_total_q     <= TotalInit;
      err_q           <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      pack_valid_q    <= pack_valid_d;
      pack_data_q     <= pack_data_d;
      pack_last_q     <= pack_last_d;
      pack_byte_cnt_q <= pack_byte_cnt_d;
      bit_total_q     <= bit_total_d;
      err_q           <= err_d;
    end
  end

  assign bus.pack_valid     = pack_valid_q;
  assign bus.pack_data      = pack_data_q;
  assign bus.pack_last      = pack_last_q;
  assign bus.pack_byte_cnt  = pack_byte_cnt_q;
  assign bus.pack_bit_total = bit_total_q;
  assign bus.busy           = (state_q == StFlush);
  assign bus.protocol_err   = err_q;

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Scoreboard bench for deflate_bit_packer: a bit-queue model predicts every packed word.
module tb_deflate_bit_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  deflate_bit_packer_if #(.OUT_WIDTH(32), .BITCNT_WIDTH(32)) bus ();
  deflate_bit_packer #(.OUT_WIDTH(32), .BITCNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  cnt;
    logic [31:0] total;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          bits_q[$];
  logic [31:0] m_total;
  bit          m_flush;
  bit          m_err;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic preload();
`ifdef DEFLATE_BIT_PACKER_HEADER_EN
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    m_total += 32'd3;
`endif
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_q.delete();
    m_total = 0;
    m_flush = 0;
    m_err   = 0;
    preload();
  endtask

  // Remaining bits, zero padded to whole bytes, form the last word.
  task automatic model_final();
    int          n;
    int          nbytes;
    logic [31:0] w;
    exp_t        e;
    n      = bits_q.size();
    nbytes = (n + 7) / 8;
    w      = 32'd0;
    for (int i = 0; i < n; i++) w[31-i] = bits_q.pop_front();
    m_total += 32'(nbytes * 8 - n);
    preload();
    e.data  = w;
    e.last  = 1'b1;
    e.cnt   = 3'(nbytes);
    e.total = m_total;
    exp_q.push_back(e);
  endtask

  task automatic model_step(bit v, int sz, logic [31:0] d, bit fl);
    int          s;
    logic [31:0] w;
    exp_t        e;
    if (m_flush) begin
      if (v) m_err = 1;
      model_final();
      m_flush = 0;
      return;
    end
    if (v) begin
      s = (sz > 32) ? 32 : sz;
      if (sz > 32) m_err = 1;
      for (int i = s - 1; i >= 0; i--) bits_q.push_back(d[i]);
      m_total += 32'(s);
    end
    if (bits_q.size() >= 32) begin
      for (int i = 0; i < 32; i++) w[31-i] = bits_q.pop_front();
      e.data  = w;
      e.last  = 1'b0;
      e.cnt   = 3'd4;
      e.total = m_total;
      exp_q.push_back(e);
      if (fl) m_flush = 1;
    end else if (fl) begin
      model_final();
    end
  endtask

  task automatic drive(bit v, int sz, logic [31:0] d, bit fl);
    bus.lz77_filt_valid = v;
    bus.lz77_filt_size  = 6'(sz);
    bus.lz77_filt_data  = d;
    bus.flush_in        = fl;
    model_step(v, sz, d, fl);
    @(posedge clk);
    #1;
    chk("busy", 32'(bus.busy), 32'(m_flush));
    chk("protocol_err", 32'(bus.protocol_err), 32'(m_err));
    bus.lz77_filt_valid = 1'b0;
    bus.flush_in        = 1'b0;
  endtask

  task automatic random_phase(int cycles, bit allow_err);
    bit v;
    int sz;
    bit fl;
    for (int c = 0; c < cycles; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      sz = (allow_err && $urandom_range(0, 15) == 0) ? int'($urandom_range(33, 63))
                                                     : int'($urandom_range(0, 32));
      fl = ($urandom_range(0, 15) == 0);
      if (m_flush && !allow_err) v = 0;
      drive(v, sz, $urandom, fl);
    end
  endtask

  task automatic check_outputs_zero(string tag, logic [31:0] total_req);
    chk({tag, "_pack_valid"}, 32'(bus.pack_valid), 32'd0);
    chk({tag, "_pack_data"}, bus.pack_data, 32'd0);
    chk({tag, "_pack_last"}, 32'(bus.pack_last), 32'd0);
    chk({tag, "_pack_byte_cnt"}, 32'(bus.pack_byte_cnt), 32'd0);
    chk({tag, "_pack_bit_total"}, bus.pack_bit_total, total_req);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_protocol_err"}, 32'(bus.protocol_err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.pack_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h required no word at %0t", bus.pack_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pack_data", bus.pack_data, mon_e.data);
        chk("pack_last", 32'(bus.pack_last), 32'(mon_e.last));
        chk("pack_byte_cnt", 32'(bus.pack_byte_cnt), 32'(mon_e.cnt));
        chk("pack_bit_total", bus.pack_bit_total, mon_e.total);
      end
    end
  end

  initial begin
    rst_n               = 1'b0;
    bus.lz77_filt_valid = 1'b0;
    bus.lz77_filt_size  = 6'd0;
    bus.lz77_filt_data  = 32'd0;
    bus.flush_in        = 1'b0;
    model_reset();
    #12;
    check_outputs_zero("reset", m_total);
    @(negedge clk);
    rst_n = 1'b1;

    // Eight bytes with flush on the last: two full words, then an empty final word.
    for (int i = 0; i < 8; i++) drive(1, 8, 32'hA1 + 32'(i), i == 7);
    repeat (3) drive(0, 0, 32'd0, 0);

    // 7 + 5 bits flushed together.
    drive(1, 7, 32'h00, 0);
    drive(1, 5, 32'h1F, 1);
    repeat (2) drive(0, 0, 32'd0, 0);

    // 20 bits held, then a full 32-bit chunk with flush forces the FLUSH cycle.
    drive(1, 20, 32'hABCDE, 0);
    drive(1, 32, 32'hFFFF_FFFF, 1);
    repeat (3) drive(0, 0, 32'd0, 0);

    random_phase(600, 0);
    drive(0, 0, 32'd0, 1);
    repeat (2) drive(0, 0, 32'd0, 0);

    // Chunk presented during FLUSH is dropped and the error sticks.
    drive(1, 24, 32'h00C0FFEE, 0);
    drive(1, 24, 32'h00123456, 1);
    drive(1, 8, 32'h55, 0);
    repeat (3) drive(0, 0, 32'd0, 0);

    // Reset with 17 bits held: nothing may come out.
    drive(1, 8, 32'h3C, 0);
    drive(1, 9, 32'h1A5, 0);
    @(negedge clk);
    #1;
    chk("pending_before_reset", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs_zero("midreset", m_total);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32, 32'h1234_5678, 0);
    drive(0, 0, 32'd0, 1);
    repeat (2) drive(0, 0, 32'd0, 0);

    // Oversized chunk is clamped to 32 bits.
    drive(1, 40, 32'hDEAD_BEEF, 0);
    repeat (2) drive(0, 0, 32'd0, 0);

    random_phase(600, 1);
    drive(0, 0, 32'd0, 1);
    repeat (3) drive(0, 0, 32'd0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
